// File: rtl/stepper_sched_if.sv
// Wishbone slave port bundle for the step scheduler.
interface stepper_sched_if;
  logic        wb_stb_i;
  logic        wb_cyc_i;
  logic        wb_we_i;
  logic [3:0]  wb_adr_i;
  logic [31:0] wb_dat_i;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o;

  modport master (
    output wb_stb_i, wb_cyc_i, wb_we_i, wb_adr_i, wb_dat_i,
    input  wb_dat_o, wb_ack_o
  );

  modport slave (
    input  wb_stb_i, wb_cyc_i, wb_we_i, wb_adr_i, wb_dat_i,
    output wb_dat_o, wb_ack_o
  );
endinterface

// File: rtl/stepper_sched.sv
// Step/dir pulse scheduler: queued timed moves executed against a free-running
// 32-bit clock counter, configured over a wishbone slave port.
//
// state | meaning
// IDLE  | no move active, waiting for a queued entry
// LOAD  | pop head entry, compute first step time
// WAIT  | waiting for counter to reach next_time, then fire a step
module stepper_sched #(
  parameter int QUEUE_DEPTH = 4,
  parameter int PULSE_TICKS = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [31:0]    counter,
  input  logic           signal_shutdown,
  stepper_sched_if.slave bus,
  output logic           step,
  output logic           dir,
  output logic           irq
);
  localparam int AW = $clog2(QUEUE_DEPTH);
  localparam logic [AW:0] DEPTH = (AW+1)'(QUEUE_DEPTH);
  localparam logic [7:0] PULSE = 8'(PULSE_TICKS);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;

  logic [1:0]    state;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   fill;
  logic          q_dir [QUEUE_DEPTH];
  logic [30:0]   q_int [QUEUE_DEPTH];
  logic [15:0]   q_cnt [QUEUE_DEPTH];
  logic [15:0]   q_add [QUEUE_DEPTH];
  logic          move_dir;
  logic [30:0]   move_int;
  logic          irq_en, overflow, shutdown;
  logic [31:0]   last_time, next_time, position;
  logic [30:0]   cur_int;
  logic [15:0]   rem, add;
  logic [7:0]    pulse;
  logic [31:0]   rdata, add_ext;
  logic          access, wr, wr_ctl, wr_lt, wr_mva, wr_mvb, wr_pos;
  logic          empty, full, busy, flush, push_req, push, pop, due, fire;

  assign access   = bus.wb_stb_i & bus.wb_cyc_i & ~bus.wb_ack_o;
  assign wr       = access & bus.wb_we_i;
  assign wr_ctl   = wr & (bus.wb_adr_i == 4'h1);
  assign wr_lt    = wr & (bus.wb_adr_i == 4'h2);
  assign wr_mva   = wr & (bus.wb_adr_i == 4'h3);
  assign wr_mvb   = wr & (bus.wb_adr_i == 4'h4);
  assign wr_pos   = wr & (bus.wb_adr_i == 4'h5);
  assign empty    = (fill == '0);
  assign full     = (fill == DEPTH);
  assign busy     = (state != IDLE);
  assign flush    = signal_shutdown | (wr_ctl & bus.wb_dat_i[2]);
  // Zero-count moves and moves arriving during shutdown are silently dropped.
  assign push_req = wr_mvb & (bus.wb_dat_i[15:0] != 16'd0) & ~shutdown & ~signal_shutdown;
  // Full is judged on occupancy before any same-cycle pop.
  assign push     = push_req & ~full;
  assign pop      = (state == LOAD);
  assign add_ext  = {{16{add[15]}}, add};
  // Signed difference keeps the compare correct across counter wrap.
  assign due      = ($signed(counter - next_time) >= 32'sd0);
  // A due step waits until the previous pulse has been low for one cycle.
  assign fire     = (state == WAIT) & due & ~step & ~flush;

  // Queue storage; contents need no reset since fill tracks validity.
  always_ff @(posedge clk) begin
    if (push) begin
      q_dir[wr_ptr] <= move_dir;
      q_int[wr_ptr] <= move_int;
      q_cnt[wr_ptr] <= bus.wb_dat_i[15:0];
      q_add[wr_ptr] <= bus.wb_dat_i[31:16];
    end
  end

  // Queue pointers, staging register and status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fill     <= '0;
      overflow <= 1'b0;
      shutdown <= 1'b0;
      irq_en   <= 1'b0;
      move_dir <= 1'b0;
      move_int <= '0;
    end else begin
      if (wr_mva) {move_dir, move_int} <= bus.wb_dat_i;
      if (wr_ctl) begin
        irq_en <= bus.wb_dat_i[0];
        if (bus.wb_dat_i[1]) begin
          overflow <= 1'b0;
          shutdown <= 1'b0;
        end
      end
      if (push_req & full) overflow <= 1'b1;
      if (signal_shutdown) shutdown <= 1'b1;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        fill   <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
        if (push & ~pop)      fill <= fill + (AW+1)'(1);
        else if (pop & ~push) fill <= fill - (AW+1)'(1);
      end
    end
  end

  // Move sequencer: load entries, schedule and count steps, track position.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      dir       <= 1'b0;
      rem       <= '0;
      cur_int   <= '0;
      add       <= '0;
      next_time <= '0;
      last_time <= '0;
      position  <= '0;
    end else begin
      if (wr_lt & ~busy) last_time <= bus.wb_dat_i;
      if (flush) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: if (!empty) state <= LOAD;
          LOAD: begin
            dir       <= q_dir[rd_ptr];
            rem       <= q_cnt[rd_ptr];
            cur_int   <= q_int[rd_ptr];
            add       <= q_add[rd_ptr];
            next_time <= last_time + {1'b0, q_int[rd_ptr]};
            state     <= WAIT;
          end
          WAIT: if (fire) begin
            position  <= dir ? position - 32'd1 : position + 32'd1;
            last_time <= next_time;
            rem       <= rem - 16'd1;
            cur_int   <= cur_int + add_ext[30:0];
            next_time <= next_time + {1'b0, cur_int} + add_ext;
            if (rem == 16'd1) state <= empty ? IDLE : LOAD;
          end
          default: state <= IDLE;
        endcase
      end
      if (wr_pos) position <= bus.wb_dat_i;
    end
  end

  // Step pulse stretcher; emergency stop drops the pulse at once.
  always_ff @(posedge clk) begin
    if (rst | signal_shutdown) begin
      step  <= 1'b0;
      pulse <= '0;
    end else if (fire) begin
      step  <= 1'b1;
      pulse <= PULSE;
    end else if (step) begin
      if (pulse == 8'd1) step <= 1'b0;
      pulse <= pulse - 8'd1;
    end
  end

  // Register read mux.
  always_comb begin
    rdata = '0;
    case (bus.wb_adr_i)
      4'h0:    rdata = {23'd0, busy, 3'(fill), irq_en, shutdown, overflow, full, empty};
      4'h2:    rdata = last_time;
      4'h5:    rdata = position;
      default: rdata = '0;
    endcase
  end

  // Single-cycle ack with registered read data, plus registered irq.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.wb_ack_o <= 1'b0;
      bus.wb_dat_o <= '0;
      irq          <= 1'b0;
    end else begin
      bus.wb_ack_o <= access;
      bus.wb_dat_o <= (access & ~bus.wb_we_i) ? rdata : '0;
      irq          <= irq_en & ((empty & ~busy) | overflow | shutdown);
    end
  end
endmodule

// File: tb/tb_stepper_sched.sv
// Bench for stepper_sched: directed scenarios plus randomized move lists,
// step times predicted from the scheduling rules with plain arithmetic.
module tb_stepper_sched;
  localparam int PT = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] counter;
  logic        signal_shutdown;
  logic        step, dir, irq;

  stepper_sched_if bus();

  stepper_sched #(.QUEUE_DEPTH(4), .PULSE_TICKS(PT)) dut (
    .clk(clk), .rst(rst), .counter(counter), .signal_shutdown(signal_shutdown),
    .bus(bus), .step(step), .dir(dir), .irq(irq)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] rise_q[$], width_q[$], exp_t_q[$];
  logic        rdir_q[$], pdir_q[$], exp_d_q[$];
  logic        mv_dir[$];
  logic [31:0] mv_int[$];
  int          mv_cnt[$], mv_add[$];
  logic [31:0] model_lt, exp_pos, rd;
  logic        prev_step = 1'b0, prev_dir = 1'b0;
  int          hi_len = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: observe outputs at the falling edge, then advance the counter.
  task automatic tick();
    @(negedge clk);
    if (step === 1'b1 && prev_step === 1'b0) begin
      rise_q.push_back(counter);
      rdir_q.push_back(dir);
      pdir_q.push_back(dir === prev_dir);
    end
    if (step === 1'b0 && prev_step === 1'b1) width_q.push_back(hi_len);
    hi_len    = (step === 1'b1) ? hi_len + 1 : 0;
    prev_step = step;
    prev_dir  = dir;
    counter   = counter + 32'd1;
  endtask

  task automatic wb_access(input logic we, input logic [3:0] a, input logic [31:0] d,
                           output logic [31:0] q);
    int n;
    bus.wb_stb_i = 1'b1; bus.wb_cyc_i = 1'b1; bus.wb_we_i = we;
    bus.wb_adr_i = a;    bus.wb_dat_i = d;
    n = 0;
    do begin tick(); n++; end while (bus.wb_ack_o !== 1'b1 && n < 8);
    check("ack_latency", n, 1);
    q = bus.wb_dat_o;
    bus.wb_stb_i = 1'b0; bus.wb_cyc_i = 1'b0; bus.wb_we_i = 1'b0;
    tick();
  endtask

  task automatic wb_write(input logic [3:0] a, input logic [31:0] d);
    logic [31:0] q;
    wb_access(1'b1, a, d, q);
  endtask

  task automatic read_check(input string tag, input logic [3:0] a, input logic [31:0] exp);
    logic [31:0] q;
    wb_access(1'b0, a, 32'd0, q);
    check(tag, q, exp);
  endtask

  task automatic push_move(input logic d, input logic [31:0] iv, input int c, input int a);
    wb_write(4'h3, {d, iv[30:0]});
    wb_write(4'h4, {a[15:0], c[15:0]});
    mv_dir.push_back(d); mv_int.push_back(iv); mv_cnt.push_back(c); mv_add.push_back(a);
  endtask

  // Step k of a move is due at last_time + interval + (interval+add) + ...;
  // a step can never come sooner than PT+1 cycles after the previous one.
  task automatic build_expect();
    logic [31:0] lt, t, prev, f, gap;
    logic [30:0] ci;
    logic        have;
    have = 1'b0; lt = model_lt; prev = '0;
    foreach (mv_cnt[m]) begin
      ci = mv_int[m][30:0];
      t  = lt + {1'b0, ci};
      for (int k = 0; k < mv_cnt[m]; k++) begin
        f = t;
        if (have) begin
          gap = t - (prev + 32'(PT + 1));
          if (gap[31]) f = prev + 32'(PT + 1);
        end
        exp_t_q.push_back(f);
        exp_d_q.push_back(mv_dir[m]);
        exp_pos = mv_dir[m] ? exp_pos - 32'd1 : exp_pos + 32'd1;
        prev = f; have = 1'b1; lt = t;
        ci = ci + 31'(mv_add[m]);
        t  = t + {1'b0, ci};
      end
    end
    mv_dir.delete(); mv_int.delete(); mv_cnt.delete(); mv_add.delete();
  endtask

  task automatic run_until(input int n, input int budget);
    int c = 0;
    while (rise_q.size() < n && c < budget) begin tick(); c++; end
    repeat (PT + 4) tick();
  endtask

  task automatic clear_obs();
    rise_q.delete(); rdir_q.delete(); pdir_q.delete(); width_q.delete();
    exp_t_q.delete(); exp_d_q.delete();
  endtask

  task automatic verify(input string tag);
    check({tag, "_nsteps"}, rise_q.size(), exp_t_q.size());
    for (int i = 0; i < rise_q.size() && i < exp_t_q.size(); i++) begin
      check($sformatf("%s_time%0d", tag, i), rise_q[i], exp_t_q[i]);
      check($sformatf("%s_dir%0d", tag, i), rdir_q[i], exp_d_q[i]);
      check($sformatf("%s_dirsetup%0d", tag, i), pdir_q[i], 1);
    end
    foreach (width_q[i]) check($sformatf("%s_width%0d", tag, i), width_q[i], PT);
    read_check({tag, "_position"}, 4'h5, exp_pos);
    clear_obs();
  endtask

  initial begin
    rst = 1'b1; counter = '0; signal_shutdown = 1'b0;
    bus.wb_stb_i = 1'b0; bus.wb_cyc_i = 1'b0; bus.wb_we_i = 1'b0;
    bus.wb_adr_i = '0;   bus.wb_dat_i = '0;
    exp_pos = '0; model_lt = '0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("rst_step", step, 0);
    check("rst_dir", dir, 0);
    check("rst_irq", irq, 0);
    check("rst_ack", bus.wb_ack_o, 0);
    check("rst_dat", bus.wb_dat_o, 0);
    read_check("rst_status", 4'h0, 32'h1);
    read_check("rst_last_time", 4'h2, 32'h0);

    // Basic three-step move from last_time=1000.
    wb_write(4'h2, 32'd1000); model_lt = 32'd1000;
    read_check("lt_readback", 4'h2, 32'd1000);
    push_move(1'b0, 32'd100, 3, 0);
    build_expect();
    run_until(3, 2000);
    verify("basic");
    read_check("basic_status", 4'h0, 32'h1);
    check("basic_irq", irq, 0);

    // Accelerating reverse move with negative add.
    counter = '0;
    wb_write(4'h5, 32'd0); exp_pos = '0;
    wb_write(4'h2, 32'd0); model_lt = '0;
    push_move(1'b1, 32'd200, 4, -10);
    build_expect();
    run_until(4, 2000);
    verify("reverse");

    // Schedule across the 32-bit counter wrap.
    counter = 32'hFFFF_FF00;
    wb_write(4'h2, 32'hFFFF_FF00); model_lt = 32'hFFFF_FF00;
    push_move(1'b0, 32'h200, 1, 0);
    build_expect();
    run_until(1, 1000);
    verify("wrap");

    // Overflow with the scheduler parked far in the future.
    counter = '0;
    wb_write(4'h2, 32'h1000_0000);
    wb_write(4'h1, 32'h1);
    wb_write(4'h3, 32'd100);
    repeat (6) wb_write(4'h4, 32'h0000_0001);
    repeat (3) tick();
    read_check("ovf_status", 4'h0, 32'h196);
    check("ovf_irq", irq, 1);
    wb_write(4'h2, 32'd5);
    read_check("lt_busy_ignored", 4'h2, 32'h1000_0000);
    wb_write(4'h1, 32'h3);
    repeat (3) tick();
    read_check("ovf_cleared", 4'h0, 32'h192);
    check("ovf_irq_clear", irq, 0);
    wb_write(4'h1, 32'h5);
    repeat (3) tick();
    read_check("flush_status", 4'h0, 32'h11);
    check("idle_irq", irq, 1);
    wb_write(4'h1, 32'h0);
    repeat (3) tick();
    check("irq_disabled", irq, 0);
    clear_obs();

    // Emergency stop in the middle of a pulse.
    counter = '0;
    wb_write(4'h2, 32'd50);
    wb_write(4'h3, 32'd20);
    wb_write(4'h4, 32'd10);
    begin
      int c = 0;
      while (rise_q.size() < 1 && c < 500) begin tick(); c++; end
    end
    check("sd_first_step", rise_q.size(), 1);
    repeat (3) tick();
    check("sd_step_high", step, 1);
    signal_shutdown = 1'b1;
    tick();
    check("sd_step_low", step, 0);
    signal_shutdown = 1'b0;
    tick();
    exp_pos = exp_pos + 32'd1;
    read_check("sd_status", 4'h0, 32'h9);
    wb_write(4'h3, 32'd20);
    wb_write(4'h4, 32'd2);
    read_check("sd_push_refused", 4'h0, 32'h9);
    read_check("sd_position", 4'h5, exp_pos);
    wb_write(4'h1, 32'h2);
    read_check("sd_cleared", 4'h0, 32'h1);
    clear_obs();

    // Back-to-back moves of opposite direction.
    counter = '0;
    wb_write(4'h5, 32'd0); exp_pos = '0;
    wb_write(4'h2, 32'd100); model_lt = 32'd100;
    push_move(1'b0, 32'd30, 3, 0);
    push_move(1'b1, 32'd30, 3, 0);
    build_expect();
    run_until(6, 2000);
    verify("pingpong");

    // Randomized move lists.
    for (int r = 0; r < 4; r++) begin
      int nm;
      counter = '0;
      wb_write(4'h2, 32'd200); model_lt = 32'd200;
      nm = int'($urandom_range(4, 1));
      for (int m = 0; m < nm; m++)
        push_move(1'($urandom_range(1)), 32'($urandom_range(60, 10)),
                  int'($urandom_range(4, 1)), int'($urandom_range(4)) - 2);
      build_expect();
      run_until(exp_t_q.size(), 3000);
      verify($sformatf("rand%0d", r));
    end

    // Reset in the middle of a move.
    counter = '0;
    wb_write(4'h2, 32'd20);
    wb_write(4'h3, 32'd20);
    wb_write(4'h4, 32'd5);
    begin
      int c = 0;
      while (rise_q.size() < 1 && c < 500) begin tick(); c++; end
    end
    tick();
    rst = 1'b1;
    tick();
    check("midrst_step", step, 0);
    rst = 1'b0;
    tick();
    read_check("midrst_status", 4'h0, 32'h1);
    read_check("midrst_position", 4'h5, 32'h0);
    read_check("midrst_last_time", 4'h2, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
